// File: rtl/sync_param_modn_updown_counter.sv
// Modulo-MOD up/down counter with parallel load, cascade terminal count and out-of-range load flag.
// Define MODN_CNT_SATURATE_EN to hold at the end of the range instead of wrapping.
module sync_param_modn_updown_counter #(
    parameter int WIDTH = 4,
    parameter int MOD   = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up_dn,
    input  logic             load_en,
    input  logic [WIDTH-1:0] data,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             load_err
);

    // The modulus may equal 2**WIDTH, so the range check needs one extra bit.
    localparam logic [WIDTH:0]   MOD_EXT = (WIDTH+1)'(MOD);
    localparam logic [WIDTH-1:0] MAX_V   = WIDTH'(MOD - 1);
    localparam logic [WIDTH-1:0] ONE_V   = WIDTH'(1);

    logic [WIDTH-1:0] q_q, q_d;
    logic             load_err_q, load_err_d;
    logic             at_max, at_zero, data_ok;

    always_comb begin
        at_max     = (q_q == MAX_V);
        at_zero    = (q_q == '0);
        data_ok    = ({1'b0, data} < MOD_EXT);
        q_d        = q_q;
        load_err_d = 1'b0;
        if (load_en) begin
            if (data_ok) begin
                q_d = data;
            end else begin
                q_d        = '0;
                load_err_d = 1'b1;
            end
        end else if (en) begin
            if (up_dn) begin
                if (at_max) begin
`ifdef MODN_CNT_SATURATE_EN
                    q_d = MAX_V;
`else
                    q_d = '0;
`endif
                end else begin
                    q_d = q_q + ONE_V;
                end
            end else begin
                if (at_zero) begin
`ifdef MODN_CNT_SATURATE_EN
                    q_d = '0;
`else
                    q_d = MAX_V;
`endif
                end else begin
                    q_d = q_q - ONE_V;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q_q        <= '0;
            load_err_q <= 1'b0;
        end else begin
            q_q        <= q_d;
            load_err_q <= load_err_d;
        end
    end

    // Cascade enable for a following stage: asserted on the step that wraps (or would wrap).
    assign tc       = en & (up_dn ? at_max : at_zero);
    assign q        = q_q;
    assign load_err = load_err_q;

endmodule

// File: tb/tb_sync_param_modn_updown_counter.sv
// Scoreboard bench: driver queues hand-derived expectations, monitor checks tc before the edge and q/load_err after it.
module tb_sync_param_modn_updown_counter;

`ifdef MODN_CNT_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // DUT 1: WIDTH=4, MOD=12
    logic       rst1 = 1'b0, en1 = 1'b0, ud1 = 1'b0, ld1 = 1'b0;
    logic [3:0] data1 = '0, q1;
    logic       tc1, err1;
    // DUT 2: WIDTH=3, MOD=8
    logic       rst2 = 1'b1, en2 = 1'b0, ud2 = 1'b0, ld2 = 1'b0;
    logic [2:0] data2 = '0, q2;
    logic       tc2, err2;

    sync_param_modn_updown_counter #(.WIDTH(4), .MOD(12)) dut1 (
        .clk(clk), .rst(rst1), .en(en1), .up_dn(ud1), .load_en(ld1),
        .data(data1), .q(q1), .tc(tc1), .load_err(err1)
    );

    sync_param_modn_updown_counter #(.WIDTH(3), .MOD(8)) dut2 (
        .clk(clk), .rst(rst2), .en(en2), .up_dn(ud2), .load_en(ld2),
        .data(data2), .q(q2), .tc(tc2), .load_err(err2)
    );

    typedef struct {
        string      name;
        bit         which;
        logic       tc;
        logic [3:0] q;
        logic       err;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;
    bit   busy  = 1'b0;

    task automatic chk(string nm, logic [3:0] act, logic [3:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: tc is combinational on the inputs just applied; q/load_err are checked after the edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                busy = 1'b1;
                e = sb.pop_front();
                chk({e.name, ".tc"}, {3'b0, (e.which ? tc2 : tc1)}, {3'b0, e.tc});
                @(posedge clk);
                #2;
                chk({e.name, ".q"}, (e.which ? {1'b0, q2} : q1), e.q);
                chk({e.name, ".load_err"}, {3'b0, (e.which ? err2 : err1)}, {3'b0, e.err});
                busy = 1'b0;
            end
        end
    end

    task automatic step(string nm, bit w, bit r, bit ld, bit e, bit ud, logic [3:0] d,
                        bit etc, logic [3:0] eq, bit eerr);
        exp_t x;
        if (!w) begin
            rst1 = r; ld1 = ld; en1 = e; ud1 = ud; data1 = d;
        end else begin
            rst2 = r; ld2 = ld; en2 = e; ud2 = ud; data2 = d[2:0];
        end
        x.name = nm; x.which = w; x.tc = etc; x.q = eq; x.err = eerr;
        sb.push_back(x);
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0] e, n;
        @(posedge clk);
        #1;

        // Reset, then up-count through the wrap at 11.
        step("rst_a", 0, 1, 0, 0, 0, 4'd0, 0, 4'd0, 0);
        step("rst_b", 0, 1, 0, 0, 0, 4'd0, 0, 4'd0, 0);
        e = 4'd0;
        for (int i = 0; i < 14; i++) begin
            n = (e == 4'd11) ? (SAT ? 4'd11 : 4'd0) : e + 4'd1;
            step("up_cnt", 0, 0, 0, 1, 1, 4'd0, (e == 4'd11), n, 0);
            e = n;
        end

        // Load 5, down-count through the wrap at 0.
        step("load5", 0, 0, 1, 0, 0, 4'd5, 0, 4'd5, 0);
        e = 4'd5;
        for (int i = 0; i < 7; i++) begin
            n = (e == 4'd0) ? (SAT ? 4'd0 : 4'd11) : e - 4'd1;
            step("dn_cnt", 0, 0, 0, 1, 0, 4'd0, (e == 4'd0), n, 0);
            e = n;
        end

        // Out-of-range loads, including data == MOD.
        step("load14", 0, 0, 1, 0, 0, 4'd14, 0, 4'd0, 1);
        step("err_clr", 0, 0, 0, 0, 0, 4'd0, 0, 4'd0, 0);
        step("load12", 0, 0, 1, 0, 0, 4'd12, 0, 4'd0, 1);
        step("load11_dn", 0, 0, 1, 1, 0, 4'd11, 1, 4'd11, 0);

        // Priority: rst over load, load over count.
        step("rst_ld7", 0, 1, 1, 1, 1, 4'd7, 1, 4'd0, 0);
        step("ld3_en", 0, 0, 1, 1, 1, 4'd3, 0, 4'd3, 0);
        step("rst_ld14", 0, 1, 1, 0, 0, 4'd14, 0, 4'd0, 0);

        // Reset mid-count at 9.
        step("load7", 0, 0, 1, 0, 0, 4'd7, 0, 4'd7, 0);
        step("up7", 0, 0, 0, 1, 1, 4'd0, 0, 4'd8, 0);
        step("up8", 0, 0, 0, 1, 1, 4'd0, 0, 4'd9, 0);
        step("rst_mid", 0, 1, 0, 1, 1, 4'd0, 0, 4'd0, 0);

        // Up-count from 10 across the top (saturate or wrap depending on build).
        step("load10", 0, 0, 1, 0, 0, 4'd10, 0, 4'd10, 0);
        e = 4'd10;
        for (int i = 0; i < 4; i++) begin
            n = (e == 4'd11) ? (SAT ? 4'd11 : 4'd0) : e + 4'd1;
            step("sat_up", 0, 0, 0, 1, 1, 4'd0, (e == 4'd11), n, 0);
            e = n;
        end

        // Hold at 11 with en=0: tc stays low whatever up_dn is.
        step("load11", 0, 0, 1, 0, 0, 4'd11, 0, 4'd11, 0);
        for (int i = 0; i < 5; i++)
            step("hold", 0, 0, 0, 0, i[0], 4'd0, 0, 4'd11, 0);

        // Direction reversal takes effect on the same edge.
        e = 4'd11;
        n = SAT ? 4'd11 : 4'd0;
        step("rev_up", 0, 0, 0, 1, 1, 4'd0, 1, n, 0);
        e = n;
        n = (e == 4'd0) ? (SAT ? 4'd0 : 4'd11) : e - 4'd1;
        step("rev_dn", 0, 0, 0, 1, 0, 4'd0, (e == 4'd0), n, 0);

        // WIDTH=3, MOD=8: modulus fills the whole range.
        step("w3_rst", 1, 1, 0, 0, 0, 4'd0, 0, 4'd0, 0);
        e = 4'd0;
        for (int i = 0; i < 9; i++) begin
            n = (e == 4'd7) ? (SAT ? 4'd7 : 4'd0) : e + 4'd1;
            step("w3_up", 1, 0, 0, 1, 1, 4'd0, (e == 4'd7), n, 0);
            e = n;
        end
        for (int i = 0; i < 5; i++)
            step("w3_hold", 1, 0, 0, 0, 1, 4'd0, 0, e, 0);

        for (int i = 0; i < 20 && (sb.size() > 0 || busy); i++)
            @(posedge clk);
        if (sb.size() > 0 || busy) begin
            tests++;
            fails++;
            $display("FAIL drain: %0d entries pending, expected 0", sb.size());
        end
        #5;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
